// File: rtl/lsu_pkg.sv
// Shared LSU types for the Wishbone load unit.
//   lsu_size_e      : access size code (byte/half/word/dword)
//   wb_load_state_e : load-unit FSM states, fixed 2-bit legacy encoding
//   size_bytes()    : number of bytes moved by a given size code
package lsu_pkg;

  typedef enum logic [1:0] {
    LSU_BYTE  = 2'd0,
    LSU_HALF  = 2'd1,
    LSU_WORD  = 2'd2,
    LSU_DWORD = 2'd3
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } wb_load_state_e;

  function automatic int unsigned size_bytes(lsu_size_e s);
    return 32'd1 << s;
  endfunction

endpackage

// File: rtl/wb_load_unit_if.sv
// Classic Wishbone bus bundle with bus-lock and grant.
//   master: drives adr, dat_ms, sel, stb, cyc, we, lock; samples gnt, ack, err, dat_sm
//   slave : the mirror image
interface wb_bus_t #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BYTES = DATA_W / 8;

  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] dat_ms;
  logic [DATA_W-1:0] dat_sm;
  logic [BYTES-1:0]  sel;
  logic              stb;
  logic              cyc;
  logic              we;
  logic              lock;
  logic              gnt;
  logic              ack;
  logic              err;

  modport master (
    output adr, dat_ms, sel, stb, cyc, we, lock,
    input  gnt, ack, err, dat_sm
  );

  modport slave (
    input  adr, dat_ms, sel, stb, cyc, we, lock,
    output gnt, ack, err, dat_sm
  );
endinterface

// File: rtl/wb_load_unit_align.sv
// Combinational result alignment for the load unit.
//   buf_i      : two-beat assembly buffer, little-endian, beat 0 in the low half
//   off_i      : byte offset of the load inside the first bus word
//   size_i     : access size
//   unsigned_i : 1 zero-extend, 0 sign-extend
//   data_o     : right-aligned, extended load data
module load_align
  import lsu_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned BYTES  = DATA_W / 8,
  localparam int unsigned OFF_W  = $clog2(BYTES)
) (
  input  logic [2*DATA_W-1:0] buf_i,
  input  logic [OFF_W-1:0]    off_i,
  input  lsu_size_e           size_i,
  input  logic                unsigned_i,
  output logic [DATA_W-1:0]   data_o
);

  logic [2*DATA_W-1:0] shifted;
  logic [DATA_W-1:0]   low;
  int unsigned         nbits;
  logic                msb;

  always_comb begin
    shifted = buf_i >> {off_i, 3'b000};
    low     = shifted[DATA_W-1:0];
    nbits   = size_bytes(size_i) * 8;
    // dword on a 32-bit bus is illegal and its data is discarded; clamp keeps the index in range
    if (nbits > DATA_W) nbits = DATA_W;
    msb    = low[nbits-1] & ~unsigned_i;
    data_o = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      data_o[i] = (i < nbits) ? low[i] : msb;
    end
  end

endmodule

// File: rtl/wb_load_unit.sv
// Wishbone load master. Takes one load request at a time, issues one or two
// read beats (two, under lock, when the access straddles a bus word) and
// returns a registered, extended result with a one-cycle valid_o pulse.
//   clk, rstn_i         : clock, asynchronous active-low reset
//   req_i/ready_o       : request handshake (accepted when both high)
//   addr_i/size_i/unsigned_i : load description, latched on acceptance
//   valid_o             : one-cycle result strobe
//   data_o/err_o/misalign_o : result, held until the next response
//   wb_bus              : Wishbone master port
module wb_load_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W           = 32,
  parameter int unsigned ADDR_W           = 32,
  parameter int unsigned ALLOW_MISALIGNED = 1,
  parameter int unsigned TIMEOUT          = 255
) (
  input  logic              clk,
  input  logic              rstn_i,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  lsu_size_e         size_i,
  input  logic              unsigned_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              err_o,
  output logic              misalign_o,
  wb_bus_t.master           wb_bus
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  wb_load_state_e      state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [OFF_W-1:0]    off_q;
  lsu_size_e           size_q;
  logic                uns_q;
  logic                split_q;
  logic [2*BYTES-1:0]  sel_full_q;
  logic [2*DATA_W-1:0] buf_q, buf_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                err_q, err_d;
  logic                mis_q, mis_d;

  // request decode
  logic [OFF_W-1:0]    off_in;
  int unsigned         nbytes_in;
  logic                illegal_in;
  logic                split_in;
  logic [2*BYTES-1:0]  mask_in;
  logic [2*BYTES-1:0]  sel_full_in;
  logic                accept;

  always_comb begin
    off_in     = addr_i[OFF_W-1:0];
    nbytes_in  = size_bytes(size_i);
    illegal_in = (DATA_W == 32) && (size_i == LSU_DWORD);
    split_in   = (32'(off_in) + nbytes_in) > BYTES;
    for (int unsigned i = 0; i < 2*BYTES; i++) begin
      mask_in[i] = (i < nbytes_in);
    end
    // lanes of both beats in one vector: low half is beat 0, high half is beat 1
    sel_full_in = mask_in << off_in;
    accept      = (state_q == IDLE) && req_i;
  end

  // bus side
  logic               in_beat;
  logic               tmo_hit;
  logic               cyc;
  logic               stb;
  logic [BYTES-1:0]   lane_sel;
  int unsigned        base;
  logic [2*DATA_W-1:0] buf_cap;
  logic [DATA_W-1:0]  aligned;

  always_comb begin
    in_beat  = (state_q == BEAT0) || (state_q == BEAT1);
    tmo_hit  = (TIMEOUT != 0) && (tmo_q == TW'(TIMEOUT));
    cyc      = in_beat && !tmo_hit;
    stb      = cyc && wb_bus.gnt;
    lane_sel = (state_q == BEAT1) ? sel_full_q[2*BYTES-1:BYTES] : sel_full_q[BYTES-1:0];
    base     = (state_q == BEAT1) ? BYTES : 0;
    buf_cap  = buf_q;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (lane_sel[i]) buf_cap[(base+i)*8 +: 8] = wb_bus.dat_sm[i*8 +: 8];
    end
  end

  assign wb_bus.cyc    = cyc;
  assign wb_bus.stb    = stb;
  assign wb_bus.lock   = cyc && split_q;
  assign wb_bus.sel    = stb ? lane_sel : '0;
  assign wb_bus.adr    = !stb ? '0 :
                         (state_q == BEAT1) ? addr_q + ADDR_W'(BYTES) : addr_q;
  assign wb_bus.we     = 1'b0;
  assign wb_bus.dat_ms = '0;

  load_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .buf_i      (buf_cap),
    .off_i      (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (aligned)
  );

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    err_d   = err_q;
    mis_d   = mis_q;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          buf_d = '0;
          tmo_d = '0;
          if (illegal_in || (split_in && ALLOW_MISALIGNED == 0)) begin
            state_d = RESP;
            data_d  = '0;
            err_d   = 1'b1;
            mis_d   = !illegal_in;
          end else begin
            state_d = BEAT0;
          end
        end
      end
      BEAT0, BEAT1: begin
        if (cyc && wb_bus.err) begin
          state_d = RESP;
          data_d  = '0;
          err_d   = 1'b1;
          mis_d   = 1'b0;
        end else if (cyc && wb_bus.ack) begin
          buf_d = buf_cap;
          tmo_d = '0;
          if (state_q == BEAT0 && split_q) begin
            state_d = BEAT1;
          end else begin
            state_d = RESP;
            data_d  = aligned;
            err_d   = 1'b0;
            mis_d   = 1'b0;
          end
        end else if (tmo_hit) begin
          state_d = RESP;
          data_d  = '0;
          err_d   = 1'b1;
          mis_d   = 1'b0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      off_q      <= '0;
      size_q     <= LSU_BYTE;
      uns_q      <= 1'b0;
      split_q    <= 1'b0;
      sel_full_q <= '0;
      buf_q      <= '0;
      tmo_q      <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
      if (accept) begin
        addr_q     <= {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        off_q      <= off_in;
        size_q     <= size_i;
        uns_q      <= unsigned_i;
        split_q    <= split_in;
        sel_full_q <= sel_full_in;
      end
    end
  end

  assign ready_o    = (state_q == IDLE);
  assign valid_o    = (state_q == RESP);
  assign data_o     = data_q;
  assign err_o      = err_q;
  assign misalign_o = mis_q;

endmodule

// File: tb/tb_wb_load_unit.sv
module tb_wb_load_unit;
  import lsu_pkg::*;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
    logic        m;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [31:0] addr = '0;
  lsu_size_e   size = LSU_BYTE;
  logic        uns = 1'b0;
  logic        ready_a, valid_a, err_a, mis_a;
  logic        ready_b, valid_b, err_b, mis_b;
  logic [31:0] data_a, data_b;
  logic        gnt_a = 1'b1, gnt_b = 1'b1;
  int unsigned mode_a = 0, mode_b = 0;   // 0 ack, 1 silent, 2 err
  logic [31:0] mem_w [0:63];

  int n_cmp = 0;
  int n_bad = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  logic [31:0] log_adr[$];
  logic [3:0]  log_sel[$];
  logic        log_lock[$];

  always #5 clk = ~clk;

  wb_bus_t #(.ADDR_W(32), .DATA_W(32)) bus_a ();
  wb_bus_t #(.ADDR_W(32), .DATA_W(32)) bus_b ();

  assign bus_a.gnt    = gnt_a;
  assign bus_a.ack    = bus_a.stb && (mode_a == 0);
  assign bus_a.err    = bus_a.stb && (mode_a == 2);
  assign bus_a.dat_sm = mem_w[bus_a.adr[7:2]];
  assign bus_b.gnt    = gnt_b;
  assign bus_b.ack    = bus_b.stb && (mode_b == 0);
  assign bus_b.err    = bus_b.stb && (mode_b == 2);
  assign bus_b.dat_sm = mem_w[bus_b.adr[7:2]];

  wb_load_unit #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGNED(1), .TIMEOUT(255)) dut_a (
    .clk(clk), .rstn_i(rstn), .req_i(req_a), .addr_i(addr), .size_i(size), .unsigned_i(uns),
    .ready_o(ready_a), .valid_o(valid_a), .data_o(data_a), .err_o(err_a), .misalign_o(mis_a),
    .wb_bus(bus_a)
  );

  wb_load_unit #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGNED(0), .TIMEOUT(4)) dut_b (
    .clk(clk), .rstn_i(rstn), .req_i(req_b), .addr_i(addr), .size_i(size), .unsigned_i(uns),
    .ready_o(ready_b), .valid_o(valid_b), .data_o(data_b), .err_o(err_b), .misalign_o(mis_b),
    .wb_bus(bus_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] w;
    w = mem_w[a[7:2]];
    return w[8*a[1:0] +: 8];
  endfunction

  function automatic exp_t model(input logic [31:0] a, input int unsigned sz, input bit u, input bit allow);
    exp_t r;
    logic [31:0] v;
    int unsigned nb;
    r = '0;
    if (sz == 3) begin r.e = 1'b1; return r; end
    nb = 1 << sz;
    if (!allow && (32'(a[1:0]) + nb > 4)) begin r.e = 1'b1; r.m = 1'b1; return r; end
    v = '0;
    for (int unsigned k = 0; k < nb; k++) v = v | (32'(mem_byte(a + k)) << (8*k));
    if (!u && v[8*nb-1]) for (int unsigned b = 8*nb; b < 32; b++) v[b] = 1'b1;
    r.d = v;
    return r;
  endfunction

  // scoreboard pop on every result strobe
  always @(negedge clk) begin
    if (rstn && valid_a) begin
      if (q_a.size() == 0) chk("a_unexpected_valid", 1, 0);
      else begin
        exp_t e;
        e = q_a.pop_front();
        chk("a_data", data_a, e.d);
        chk("a_err", err_a, e.e);
        chk("a_mis", mis_a, e.m);
      end
    end
    if (rstn && valid_b) begin
      if (q_b.size() == 0) chk("b_unexpected_valid", 1, 0);
      else begin
        exp_t e;
        e = q_b.pop_front();
        chk("b_data", data_b, e.d);
        chk("b_err", err_b, e.e);
        chk("b_mis", mis_b, e.m);
      end
    end
  end

  task automatic issue(input bit to_b, input logic [31:0] a, input int unsigned sz, input bit u,
                       input bit push, input bit force_err);
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < 20 && !(to_b ? ready_b : ready_a); i++) @(negedge clk);
    if (!(to_b ? ready_b : ready_a)) chk("ready_wait", 0, 1);
    addr = a;
    size = lsu_size_e'(sz[1:0]);
    uns  = u;
    e = model(a, sz, u, !to_b);
    if (force_err) begin e.d = '0; e.e = 1'b1; e.m = 1'b0; end
    if (push) begin
      if (to_b) q_b.push_back(e);
      else q_a.push_back(e);
    end
    if (to_b) req_b = 1'b1;
    else req_a = 1'b1;
    @(posedge clk);
    #1;
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  // lat counts edges from acceptance: 1 = visible right after the accept edge
  task automatic wait_valid(input bit to_b, output int lat, output int ncyc);
    log_adr.delete(); log_sel.delete(); log_lock.delete();
    lat = 1;
    ncyc = 0;
    for (int i = 0; i < 40; i++) begin
      if (to_b ? bus_b.cyc : bus_a.cyc) ncyc++;
      if (to_b ? bus_b.stb : bus_a.stb) begin
        log_adr.push_back(to_b ? bus_b.adr : bus_a.adr);
        log_sel.push_back(to_b ? bus_b.sel : bus_a.sel);
        log_lock.push_back(to_b ? bus_b.lock : bus_a.lock);
      end
      if (to_b ? valid_b : valid_a) return;
      @(posedge clk);
      #1;
      lat++;
    end
    chk("valid_wait_expired", 0, 1);
  endtask

  initial begin
    int lat, ncyc;
    for (int i = 0; i < 64; i++) mem_w[i] = 32'h1111_1111 * 32'(i % 15) ^ 32'hA5C3_0F96;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready_a, 1);
    chk("rst_valid", valid_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_mis", mis_a, 0);
    chk("rst_cyc_stb_lock", {bus_a.cyc, bus_a.stb, bus_a.lock}, 0);
    chk("rst_sel", bus_a.sel, 0);
    @(negedge clk);
    rstn = 1'b1;

    // 1: aligned word
    mem_w[0] = 32'h8765_4321;
    issue(0, 32'h100, 2, 0, 1, 0);
    wait_valid(0, lat, ncyc);
    chk("lw_latency", lat, 2);
    chk("lw_beats", log_adr.size(), 1);
    if (log_adr.size() >= 1) begin
      chk("lw_adr", log_adr[0], 32'h100);
      chk("lw_sel", log_sel[0], 4'b1111);
      chk("lw_lock", log_lock[0], 0);
    end

    // 2: byte at the top lane, signed and unsigned; half inside the word
    mem_w[0] = 32'h8012_3456;
    issue(0, 32'h103, 0, 0, 1, 0);
    wait_valid(0, lat, ncyc);
    if (log_sel.size() >= 1) chk("lb_sel", log_sel[0], 4'b1000);
    issue(0, 32'h103, 0, 1, 1, 0);
    wait_valid(0, lat, ncyc);
    issue(0, 32'h101, 1, 1, 1, 0);
    wait_valid(0, lat, ncyc);
    if (log_sel.size() >= 1) chk("lhu_sel", log_sel[0], 4'b0110);

    // 3: misaligned word split across two locked beats
    mem_w[0] = 32'hBBBB_AAAA;
    mem_w[1] = 32'hDDDD_CCCC;
    issue(0, 32'h102, 2, 0, 1, 0);
    wait_valid(0, lat, ncyc);
    chk("split_latency", lat, 3);
    chk("split_beats", log_adr.size(), 2);
    if (log_adr.size() >= 2) begin
      chk("split_adr0", log_adr[0], 32'h100);
      chk("split_sel0", log_sel[0], 4'b1100);
      chk("split_adr1", log_adr[1], 32'h104);
      chk("split_sel1", log_sel[1], 4'b0011);
      chk("split_lock", {log_lock[0], log_lock[1]}, 2'b11);
    end

    // illegal dword on a 32-bit bus: no bus cycle
    issue(0, 32'h100, 3, 0, 1, 0);
    wait_valid(0, lat, ncyc);
    chk("dword_no_cyc", ncyc, 0);
    chk("dword_latency", lat, 1);

    // 4: misaligned load rejected when splitting is disabled
    issue(1, 32'h102, 2, 0, 1, 0);
    wait_valid(1, lat, ncyc);
    chk("mis_no_cyc", ncyc, 0);
    chk("mis_latency", lat, 1);

    // 5: slave error in beat 0 of a split load
    mode_a = 2;
    issue(0, 32'h102, 2, 0, 1, 1);
    wait_valid(0, lat, ncyc);
    chk("err_one_beat", log_adr.size(), 1);
    if (log_adr.size() >= 1) chk("err_beat_adr", log_adr[0], 32'h100);
    mode_a = 0;

    // 5: grant withheld for five cycles
    mem_w[0] = 32'h0BAD_F00D;
    gnt_a = 1'b0;
    issue(0, 32'h100, 2, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      chk("nognt_stb_cyc_sel", {bus_a.stb, bus_a.cyc, bus_a.sel}, {1'b0, 1'b1, 4'b0000});
      @(posedge clk);
      #1;
    end
    gnt_a = 1'b1;
    wait_valid(0, lat, ncyc);
    chk("nognt_latency", lat, 2);

    // 6: timeout after four silent cycles
    mode_b = 1;
    issue(1, 32'h100, 2, 0, 1, 1);
    wait_valid(1, lat, ncyc);
    chk("tmo_cyc_cycles", ncyc, 4);
    mode_b = 0;

    // 6: reset in the middle of a beat
    mode_a = 1;
    issue(0, 32'h100, 2, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("pre_rst_cyc", bus_a.cyc, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_mid_cyc_stb_lock", {bus_a.cyc, bus_a.stb, bus_a.lock}, 0);
    @(negedge clk);
    rstn = 1'b1;
    mode_a = 0;
    @(posedge clk);
    #1;
    chk("post_rst_ready", ready_a, 1);
    chk("post_rst_valid", valid_a, 0);

    // recovery plus random traffic
    mem_w[1] = 32'hDDDD_CCCC;
    issue(0, 32'h106, 1, 0, 1, 0);
    wait_valid(0, lat, ncyc);
    for (int i = 0; i < 24; i++) begin
      int unsigned sz;
      logic [31:0] a;
      sz = $urandom_range(0, 2);
      a  = 32'h100 + 32'($urandom_range(0, 240));
      issue(0, a, sz, 1'($urandom_range(0, 1)), 1, 0);
      wait_valid(0, lat, ncyc);
      chk("rand_latency", lat, (32'(a[1:0]) + (1 << sz) > 4) ? 3 : 2);
    end

    repeat (3) @(posedge clk);
    chk("q_a_drained", q_a.size(), 0);
    chk("q_b_drained", q_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
